// File: rtl/if_id_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_id_fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register of the MIPS32 core.
//   Owns the PC, issues one outstanding fetch at a time over a req/ack
//   handshake, and delivers Instruction_ID / PC_plus4_ID to decode.
//
// Handshake: imem_req is raised with imem_addr and both are held stable
//   until imem_ack is seen (one cycle, same cycle as valid imem_rdata).
//   A request is complete on the edge where imem_req && imem_ack.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   imem_req/imem_addr       fetch request and word-aligned address
//   imem_rdata/imem_ack      fetch data and completion strobe
//   stall_IF                 hold PC and IF/ID
//   flush_IF                 bubble IF/ID on next edge
//   redirect_valid/_pc       branch/jump redirect (highest priority)
//   Instruction_ID           IF/ID instruction
//   PC_plus4_ID              IF/ID PC+4
//   valid_ID                 IF/ID holds a real instruction
//   fetch_busy               DRAIN, or FETCH waiting for ack
//   dbg_state_o              current FSM state (BOOT=0 FETCH=1 HOLD=2 DRAIN=3)
//
// Optional feature macro: IF_ID_PERF_CNT_EN
//   Adds perf_fetch_cnt / perf_bubble_cnt counters and output ports.
// ---------------------------------------------------------------------------
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall_IF,
  input  logic        flush_IF,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] Instruction_ID,
  output logic [31:0] PC_plus4_ID,
  output logic        valid_ID,
  output logic        fetch_busy,
  output logic [1:0]  dbg_state_o
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] skid_q, skid_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        vld_q, vld_d;
  logic        ifid_load;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic        outstanding;

  assign pc_plus4     = pc_q + 32'd4;  // wraps FFFF_FFFC -> 0000_0000
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign outstanding  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_BOOT;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      // An unacked request must still be completed before refetching.
      state_d = (outstanding && !imem_ack) ? ST_DRAIN : ST_FETCH;
    end else begin
      unique case (state_q)
        ST_BOOT:  state_d = ST_FETCH;
        ST_FETCH: if (imem_ack && stall_IF) state_d = ST_HOLD;
        ST_HOLD:  if (!stall_IF) state_d = ST_FETCH;
        ST_DRAIN: if (imem_ack) state_d = ST_FETCH;
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    imem_req    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    imem_addr   = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    fetch_busy  = (state_q == ST_DRAIN) || ((state_q == ST_FETCH) && !imem_ack);
    dbg_state_o = state_q;
  end

  // PC, skid buffer and IF/ID next values
  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_d       = skid_q;
    skid_vld_d   = skid_vld_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    vld_d        = vld_q;
    ifid_load    = 1'b0;

    if (redirect_valid) begin
      pc_d       = redirect_tgt;
      skid_vld_d = 1'b0;
      // Keep presenting the old address while the stale response drains.
      if (outstanding && !imem_ack) drain_addr_d = imem_addr;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (imem_ack && stall_IF) begin
            skid_d     = imem_rdata;
            skid_vld_d = 1'b1;
          end else if (imem_ack) begin
            pc_d = pc_plus4;
          end
        end
        ST_HOLD: begin
          if (!stall_IF) begin
            pc_d       = pc_plus4;
            skid_vld_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // Flush/redirect beat stall and any same-cycle ack write.
    if (flush_IF || redirect_valid) begin
      ifid_load = 1'b1;
      instr_d   = BUBBLE_INSTR;
      pc4_d     = 32'd0;
      vld_d     = 1'b0;
    end else if (!stall_IF) begin
      ifid_load = 1'b1;
      if ((state_q == ST_FETCH) && imem_ack) begin
        instr_d = imem_rdata;
        pc4_d   = pc_plus4;
        vld_d   = 1'b1;
      end else if ((state_q == ST_HOLD) && skid_vld_q) begin
        instr_d = skid_q;
        pc4_d   = pc_plus4;
        vld_d   = 1'b1;
      end else begin
        instr_d = BUBBLE_INSTR;
        pc4_d   = 32'd0;
        vld_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_PC_W;
      drain_addr_q <= RESET_PC_W;
      skid_q       <= 32'd0;
      skid_vld_q   <= 1'b0;
      instr_q      <= BUBBLE_INSTR;
      pc4_q        <= 32'd0;
      vld_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_q       <= skid_d;
      skid_vld_q   <= skid_vld_d;
      if (ifid_load) begin
        instr_q <= instr_d;
        pc4_q   <= pc4_d;
        vld_q   <= vld_d;
      end
    end
  end

  assign Instruction_ID = instr_q;
  assign PC_plus4_ID    = pc4_q;
  assign valid_ID       = vld_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_bubble_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_q  <= 32'd0;
      perf_bubble_q <= 32'd0;
    end else if (ifid_load) begin
      if (vld_d) perf_fetch_q  <= perf_fetch_q + 32'd1;
      else       perf_bubble_q <= perf_bubble_q + 32'd1;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_fetch_stage
//   Directed bench for if_id_fetch_stage. A memory responder answers
//   requests (auto-ack or forced), the main process drives stall / flush /
//   redirect / reset and pushes expected IF/ID loads into exp_q; a monitor
//   pops and compares whenever a new valid instruction appears in IF/ID.
// ---------------------------------------------------------------------------
module tb_if_id_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] BUBBLE = 32'h0000_0021;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ack = 1'b0;
  logic        stall_IF = 1'b0;
  logic        flush_IF = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] Instruction_ID;
  logic [31:0] PC_plus4_ID;
  logic        valid_ID;
  logic        fetch_busy;
  logic [1:0]  dbg_state;

  // responder controls (written by main only)
  logic        ack_mode = 1'b1;   // 0: ack whenever req, 1: drive ack_force
  logic        ack_force = 1'b0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'd0;

  logic [63:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  if_id_fetch_stage #(.RESET_PC(RST_PC), .BUBBLE_INSTR(BUBBLE)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .stall_IF(stall_IF), .flush_IF(flush_IF),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .Instruction_ID(Instruction_ID), .PC_plus4_ID(PC_plus4_ID),
    .valid_ID(valid_ID), .fetch_busy(fetch_busy), .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2000_0000 | {4'h0, a[27:0]};
  endfunction

  // memory responder: updates 2 time units after each rising edge
  always begin
    @(posedge clk);
    #2;
    imem_ack   = ack_mode ? ack_force : imem_req;
    imem_rdata = ovr_en ? ovr_val : mem_word(imem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: compare each newly loaded valid IF/ID entry
  logic        prev_vld = 1'b0;
  logic [31:0] prev_instr = 32'd0;
  logic [31:0] prev_pc4 = 32'd0;

  always @(negedge clk) begin
    if (reset_n && valid_ID &&
        (!prev_vld || Instruction_ID != prev_instr || PC_plus4_ID != prev_pc4)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL ifid_unexpected: got %h/%h expected none", Instruction_ID, PC_plus4_ID);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({Instruction_ID, PC_plus4_ID} !== e) begin
          bad++;
          $display("FAIL ifid_seq: got %h/%h expected %h/%h",
                   Instruction_ID, PC_plus4_ID, e[63:32], e[31:0]);
        end
      end
    end
    prev_vld   = reset_n && valid_ID;
    prev_instr = Instruction_ID;
    prev_pc4   = PC_plus4_ID;
  end

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_instr", Instruction_ID, BUBBLE);
    check("rst_pc4", PC_plus4_ID, 32'd0);
    check("rst_valid", {31'd0, valid_ID}, 32'd0);
    check("rst_busy", {31'd0, fetch_busy}, 32'd0);

    // cycle a: BOOT, then back-to-back fetches with ack every cycle
    step();
    reset_n  = 1'b1;
    ack_mode = 1'b0;
    exp_q.push_back({mem_word(32'h0040_0000), 32'h0040_0004});
    exp_q.push_back({mem_word(32'h0040_0004), 32'h0040_0008});
    exp_q.push_back({mem_word(32'h0040_0008), 32'h0040_000C});
    exp_q.push_back({mem_word(32'h0040_000C), 32'h0040_0010});
    @(negedge clk);
    check("boot_req", {31'd0, imem_req}, 32'd0);
    step();  // a+1
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0040_0000);
    check("first_busy", {31'd0, fetch_busy}, 32'd0);
    repeat (3) step();  // a+2..a+4

    // a+5: stall coinciding with ack of 8C22_0004
    step();
    stall_IF = 1'b1;
    ovr_en   = 1'b1;
    ovr_val  = 32'h8C22_0004;
    exp_q.push_back({32'h8C22_0004, 32'h0040_0014});
    @(negedge clk);
    check("pre_stall_instr", Instruction_ID, mem_word(32'h0040_000C));
    step();  // a+6
    ovr_en = 1'b0;
    @(negedge clk);
    check("hold_state", {30'd0, dbg_state}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) stall_IF = 1'b0;  // a+8: released, still in HOLD
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_instr", Instruction_ID, mem_word(32'h0040_000C));
      check("hold_pc4", PC_plus4_ID, 32'h0040_0010);
      check("hold_valid", {31'd0, valid_ID}, 32'd1);
      if (i < 2) begin
        step();
        @(negedge clk);
      end
    end

    // a+9: redirect to 0x20 with a same-cycle ack (discarded)
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0020;
    @(negedge clk);
    check("skid_instr", Instruction_ID, 32'h8C22_0004);
    // a+10: request to 0x20 unacked, redirect to 0x100
    step();
    ack_mode    = 1'b1;
    ack_force   = 1'b0;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    check("redir_addr", imem_addr, 32'h0000_0020);
    check("redir_busy", {31'd0, fetch_busy}, 32'd1);
    check("redir_valid", {31'd0, valid_ID}, 32'd0);
    step();  // a+11: DRAIN
    redirect_valid = 1'b0;
    @(negedge clk);
    check("drain_state", {30'd0, dbg_state}, 32'd3);
    check("drain_addr", imem_addr, 32'h0000_0020);
    check("drain_req", {31'd0, imem_req}, 32'd1);
    check("drain_valid", {31'd0, valid_ID}, 32'd0);
    step();  // a+12: ack of stale response
    ack_force = 1'b1;
    @(negedge clk);
    check("drain_ack_addr", imem_addr, 32'h0000_0020);
    check("drain_ack_busy", {31'd0, fetch_busy}, 32'd1);
    step();  // a+13
    ack_force = 1'b0;
    @(negedge clk);
    check("post_drain_addr", imem_addr, 32'h0000_0100);
    check("post_drain_valid", {31'd0, valid_ID}, 32'd0);
    check("post_drain_busy", {31'd0, fetch_busy}, 32'd1);

    // a+14: one fetch at 0x100, then flush+stall together
    step();
    ack_mode = 1'b0;
    exp_q.push_back({mem_word(32'h0000_0100), 32'h0000_0104});
    step();  // a+15
    ack_mode  = 1'b1;
    ack_force = 1'b0;
    flush_IF  = 1'b1;
    stall_IF  = 1'b1;
    @(negedge clk);
    check("pre_flush_valid", {31'd0, valid_ID}, 32'd1);

    // a+16: redirect to FFFF_FFFF (low bits ignored) with ack discarded
    step();
    flush_IF       = 1'b0;
    stall_IF       = 1'b0;
    ack_mode       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    @(negedge clk);
    check("flush_valid", {31'd0, valid_ID}, 32'd0);
    check("flush_instr", Instruction_ID, BUBBLE);
    step();  // a+17
    redirect_valid = 1'b0;
    exp_q.push_back({mem_word(32'hFFFF_FFFC), 32'h0000_0000});
    @(negedge clk);
    check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    step();  // a+18
    ack_mode  = 1'b1;
    ack_force = 1'b0;
    @(negedge clk);
    check("wrap_next_addr", imem_addr, 32'h0000_0000);
    check("wrap_pc4", PC_plus4_ID, 32'h0000_0000);
    check("wrap_valid", {31'd0, valid_ID}, 32'd1);

    // async reset mid-FETCH, then a stale ack
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_addr", imem_addr, RST_PC);
    check("mid_rst_instr", Instruction_ID, BUBBLE);
    check("mid_rst_pc4", PC_plus4_ID, 32'd0);
    check("mid_rst_valid", {31'd0, valid_ID}, 32'd0);
    step();  // a+19: BOOT with stale ack
    reset_n   = 1'b1;
    ack_force = 1'b1;
    @(negedge clk);
    check("stale_req", {31'd0, imem_req}, 32'd0);
    check("stale_busy", {31'd0, fetch_busy}, 32'd0);
    step();  // a+20
    ack_force = 1'b0;
    @(negedge clk);
    check("stale_valid", {31'd0, valid_ID}, 32'd0);
    check("stale_instr", Instruction_ID, BUBBLE);
    check("refetch_addr", imem_addr, RST_PC);
    check("refetch_req", {31'd0, imem_req}, 32'd1);
    step();  // a+21: one fetch after reset
    ack_mode = 1'b0;
    exp_q.push_back({mem_word(RST_PC), RST_PC + 32'd4});
    step();  // a+22
    ack_mode  = 1'b1;
    ack_force = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
